// File: rtl/ppu_timing_pkg.sv
// ppu_timing_pkg
//   Timing constants and helpers shared by the PPU H/V counter and its dot
//   divider: line lengths in master-clock ticks, long-dot positions, line
//   counts per standard, blanking thresholds and the short-line index.
package ppu_timing_pkg;

    localparam logic [10:0] LINE_TICKS_NORMAL = 11'd1364;
    localparam logic [10:0] LINE_TICKS_SHORT  = 11'd1360;
    localparam logic [10:0] LINE_TICKS_LONG   = 11'd1368;

    localparam logic [8:0]  LONG_DOT_A        = 9'd323;
    localparam logic [8:0]  LONG_DOT_B        = 9'd327;

    localparam logic [8:0]  LINES_NTSC        = 9'd262;
    localparam logic [8:0]  LINES_PAL         = 9'd312;

    localparam logic [8:0]  HBLANK_START      = 9'd274;
    localparam logic [8:0]  VBLANK_START      = 9'd225;
    localparam logic [8:0]  SHORT_LINE_V      = 9'd240;

    typedef enum logic [1:0] {
        LINE_NORMAL,
        LINE_SHORT,
        LINE_LONG
    } line_t;

    // Total ticks in a line of the given type.
    function automatic logic [10:0] line_ticks(input line_t lt);
        case (lt)
            LINE_SHORT: return LINE_TICKS_SHORT;
            LINE_LONG:  return LINE_TICKS_LONG;
            default:    return LINE_TICKS_NORMAL;
        endcase
    endfunction

    // Ticks in dot h. The short line drops the two 6-tick dots.
    function automatic logic [2:0] dot_len(input logic [8:0] h, input line_t lt);
        if (lt != LINE_SHORT && (h == LONG_DOT_A || h == LONG_DOT_B))
            return 3'd6;
        return 3'd4;
    endfunction

endpackage

// File: rtl/ppu_dot_divider.sv
// ppu_dot_divider
//   Counts master-clock ticks within the current dot and flags the tick that
//   ends it.
//   clock, reset : clock, async active-high reset
//   tick         : master-clock tick enable
//   hcount       : current dot number H
//   line_type    : normal / short / long line
//   dot_end      : combinational, high on the tick that ends the dot
module ppu_dot_divider
    import ppu_timing_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic [8:0] hcount,
    input  line_t      line_type,
    output logic       dot_end
);

    logic [2:0] phase;

    assign dot_end = tick && (phase == dot_len(hcount, line_type) - 3'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            phase <= 3'd0;
        else if (tick)
            phase <= dot_end ? 3'd0 : phase + 3'd1;
    end

endmodule

// File: rtl/ppu_hv_counter.sv
// ppu_hv_counter
//   PPU beam position counter. Advances one master-clock tick per xin_tick_i
//   and tracks master-clock position in the line, dot (H), line (V), field,
//   frame count and blanking.
//   clock, reset   : clock, async active-high reset
//   xin_tick_i     : one pulse per PPU master-clock edge
//   pal_i          : 1 = PAL (312 lines), 0 = NTSC (262 lines)
//   interlace_i    : interlace mode
//   mclk_o         : tick position within the line
//   hcount_o       : dot H;  vcount_o : line V
//   dot_o / newline_o / newframe_o : one-cycle event pulses
//   field_o        : field bit;  frame_count_o : completed frames
//   hblank_o / vblank_o : blanking flags
module ppu_hv_counter
    import ppu_timing_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        xin_tick_i,
    input  logic        pal_i,
    input  logic        interlace_i,
    output logic [10:0] mclk_o,
    output logic [8:0]  hcount_o,
    output logic [8:0]  vcount_o,
    output logic        dot_o,
    output logic        newline_o,
    output logic        newframe_o,
    output logic        field_o,
    output logic        hblank_o,
    output logic        vblank_o,
    output logic [15:0] frame_count_o
);

    // init marks the first cycle after reset release, where the mode inputs
    // are captured; during that cycle the live inputs are used directly.
    logic       init;
    logic       pal_q;
    logic       ilace_q;
    logic       pal_eff;
    logic       ilace_eff;
    line_t      line_type;
    logic       dot_end;
    logic       line_end;
    logic       frame_end;
    logic [8:0] last_line;
    logic [8:0] h_next;
    logic [8:0] v_next;

    assign pal_eff   = init ? pal_i       : pal_q;
    assign ilace_eff = init ? interlace_i : ilace_q;
    assign last_line = (pal_eff ? LINES_PAL : LINES_NTSC) - 9'd1;

    always_comb begin
        line_type = LINE_NORMAL;
        if (!pal_eff && !ilace_eff && field_o && vcount_o == SHORT_LINE_V)
            line_type = LINE_SHORT;
        else if (pal_eff && ilace_eff && field_o && vcount_o == last_line)
            line_type = LINE_LONG;
    end

    ppu_dot_divider u_div (
        .clock     (clock),
        .reset     (reset),
        .tick      (xin_tick_i),
        .hcount    (hcount_o),
        .line_type (line_type),
        .dot_end   (dot_end)
    );

    // The last dot of a line ends exactly on the line's final tick.
    assign line_end  = dot_end && (mclk_o == line_ticks(line_type) - 11'd1);
    assign frame_end = line_end && (vcount_o == last_line);

    assign h_next = line_end  ? 9'd0 : (dot_end  ? hcount_o + 9'd1 : hcount_o);
    assign v_next = frame_end ? 9'd0 : (line_end ? vcount_o + 9'd1 : vcount_o);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            init          <= 1'b1;
            pal_q         <= 1'b0;
            ilace_q       <= 1'b0;
            mclk_o        <= 11'd0;
            hcount_o      <= 9'd0;
            vcount_o      <= 9'd0;
            dot_o         <= 1'b0;
            newline_o     <= 1'b0;
            newframe_o    <= 1'b0;
            field_o       <= 1'b0;
            hblank_o      <= 1'b1;
            vblank_o      <= 1'b1;
            frame_count_o <= 16'd0;
        end else begin
            dot_o      <= 1'b0;
            newline_o  <= 1'b0;
            newframe_o <= 1'b0;
            if (init) begin
                init    <= 1'b0;
                pal_q   <= pal_i;
                ilace_q <= interlace_i;
            end
            if (xin_tick_i) begin
                dot_o      <= dot_end;
                newline_o  <= line_end;
                newframe_o <= frame_end;
                mclk_o     <= line_end ? 11'd0 : mclk_o + 11'd1;
                hcount_o   <= h_next;
                vcount_o   <= v_next;
                hblank_o   <= (h_next >= HBLANK_START) || (h_next == 9'd0);
                vblank_o   <= (v_next >= VBLANK_START) || (v_next == 9'd0);
                if (frame_end) begin
                    field_o       <= ~field_o;
                    frame_count_o <= frame_count_o + 16'd1;
                    pal_q         <= pal_i;
                    ilace_q       <= interlace_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_ppu_hv_counter.sv
// tb_ppu_hv_counter
//   Directed bench for ppu_hv_counter: a table of checkpoints across the
//   first NTSC line, then hand-written sequences for stall, async reset,
//   frame end, the PAL long line and the NTSC short line.
module tb_ppu_hv_counter;

    logic        clock = 1'b0;
    logic        reset;
    logic        xin_tick_i;
    logic        pal_i;
    logic        interlace_i;
    logic [10:0] mclk_o;
    logic [8:0]  hcount_o;
    logic [8:0]  vcount_o;
    logic        dot_o;
    logic        newline_o;
    logic        newframe_o;
    logic        field_o;
    logic        hblank_o;
    logic        vblank_o;
    logic [15:0] frame_count_o;

    ppu_hv_counter dut (
        .clock         (clock),
        .reset         (reset),
        .xin_tick_i    (xin_tick_i),
        .pal_i         (pal_i),
        .interlace_i   (interlace_i),
        .mclk_o        (mclk_o),
        .hcount_o      (hcount_o),
        .vcount_o      (vcount_o),
        .dot_o         (dot_o),
        .newline_o     (newline_o),
        .newframe_o    (newframe_o),
        .field_o       (field_o),
        .hblank_o      (hblank_o),
        .vblank_o      (vblank_o),
        .frame_count_o (frame_count_o)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int n_dot, n_line, n_frame, since_dot;
    int dot_len [0:340];

    typedef struct {
        int ticks;   // cumulative ticks since reset release
        int mclk;
        int h;
        int v;
        bit hbl;
        bit vbl;
        bit dot;
        bit nl;
        bit stall;   // run the 50-cycle stall sequence after this point
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        int h0;
        h0 = hcount_o;
        xin_tick_i = 1'b1;
        @(posedge clock);
        #1;
        xin_tick_i = 1'b0;
        since_dot++;
        if (dot_o) begin
            n_dot++;
            if (h0 <= 340) dot_len[h0] = since_dot;
            since_dot = 0;
        end
        if (newline_o)  n_line++;
        if (newframe_o) n_frame++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_dots();
        for (int i = 0; i <= 340; i++) dot_len[i] = 0;
    endtask

    initial begin
        int done;
        int bad;
        int pulses;

        //            ticks mclk  h    v  hbl vbl dot nl stall
        vecs[0]  = '{    1,    1,   0, 0, 1, 1, 0, 0, 0};
        vecs[1]  = '{    3,    3,   0, 0, 1, 1, 0, 0, 0};
        vecs[2]  = '{    4,    4,   1, 0, 0, 1, 1, 0, 0};
        vecs[3]  = '{  400,  400, 100, 0, 0, 1, 1, 0, 1};
        vecs[4]  = '{  401,  401, 100, 0, 0, 1, 0, 0, 0};
        vecs[5]  = '{ 1095, 1095, 273, 0, 0, 1, 0, 0, 0};
        vecs[6]  = '{ 1096, 1096, 274, 0, 1, 1, 1, 0, 0};
        vecs[7]  = '{ 1292, 1292, 323, 0, 1, 1, 1, 0, 0};
        vecs[8]  = '{ 1296, 1296, 323, 0, 1, 1, 0, 0, 0};
        vecs[9]  = '{ 1298, 1298, 324, 0, 1, 1, 1, 0, 0};
        vecs[10] = '{ 1310, 1310, 327, 0, 1, 1, 1, 0, 0};
        vecs[11] = '{ 1316, 1316, 328, 0, 1, 1, 1, 0, 0};
        vecs[12] = '{ 1363, 1363, 339, 0, 1, 1, 0, 0, 0};
        vecs[13] = '{ 1364,    0,   0, 1, 1, 0, 1, 1, 0};

        reset = 1'b1; xin_tick_i = 1'b0; pal_i = 1'b0; interlace_i = 1'b0;
        n_dot = 0; n_line = 0; n_frame = 0; since_dot = 0;
        clear_dots();

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_mclk", mclk_o, 0);
        chk("rst_h", hcount_o, 0);
        chk("rst_v", vcount_o, 0);
        chk("rst_hblank", hblank_o, 1);
        chk("rst_vblank", vblank_o, 1);
        chk("rst_dot", dot_o, 0);
        chk("rst_field", field_o, 0);
        chk("rst_fcount", frame_count_o, 0);
        reset = 1'b0;

        // Async reset mid-line at H=200, V=50
        run(50 * 1364 + 800);
        chk("pre_areset_h", hcount_o, 200);
        chk("pre_areset_v", vcount_o, 50);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("areset_mclk", mclk_o, 0);
        chk("areset_h", hcount_o, 0);
        chk("areset_v", vcount_o, 0);
        chk("areset_hblank", hblank_o, 1);
        chk("areset_vblank", vblank_o, 1);
        #2 reset = 1'b0;

        // First NTSC line, checkpoint table
        n_dot = 0; n_line = 0; n_frame = 0; since_dot = 0;
        clear_dots();
        done = 0;
        for (int i = 0; i < 14; i++) begin
            run(vecs[i].ticks - done);
            done = vecs[i].ticks;
            chk($sformatf("v%0d_mclk", i), mclk_o, vecs[i].mclk);
            chk($sformatf("v%0d_h", i), hcount_o, vecs[i].h);
            chk($sformatf("v%0d_v", i), vcount_o, vecs[i].v);
            chk($sformatf("v%0d_hblank", i), hblank_o, vecs[i].hbl);
            chk($sformatf("v%0d_vblank", i), vblank_o, vecs[i].vbl);
            chk($sformatf("v%0d_dot", i), dot_o, vecs[i].dot);
            chk($sformatf("v%0d_newline", i), newline_o, vecs[i].nl);
            if (vecs[i].stall) begin
                pulses = 0;
                for (int c = 0; c < 50; c++) begin
                    @(posedge clock);
                    #1;
                    if (dot_o || newline_o || newframe_o) pulses++;
                end
                chk("stall_pulses", pulses, 0);
                chk("stall_mclk", mclk_o, 400);
                chk("stall_h", hcount_o, 100);
                chk("stall_v", vcount_o, 0);
                chk("stall_hblank", hblank_o, 0);
                chk("stall_vblank", vblank_o, 1);
                chk("stall_field", field_o, 0);
            end
        end
        chk("line0_dots", n_dot, 340);
        chk("line0_newlines", n_line, 1);
        chk("line0_len_h0", dot_len[0], 4);
        chk("line0_len_h323", dot_len[323], 6);
        chk("line0_len_h327", dot_len[327], 6);
        chk("line0_len_h339", dot_len[339], 4);

        // Vertical blank boundary
        run(223 * 1364);
        chk("v224_v", vcount_o, 224);
        chk("v224_vblank", vblank_o, 0);
        run(1364);
        chk("v225_v", vcount_o, 225);
        chk("v225_vblank", vblank_o, 1);

        // Mode change mid-frame must wait for frame end
        pal_i = 1'b1; interlace_i = 1'b1;
        run(37 * 1364 - 1);
        chk("f0_last_v", vcount_o, 261);
        chk("f0_last_h", hcount_o, 339);
        chk("f0_frames_before", n_frame, 0);
        tick();
        chk("f0_end_v", vcount_o, 0);
        chk("f0_end_h", hcount_o, 0);
        chk("f0_end_mclk", mclk_o, 0);
        chk("f0_end_newframe", newframe_o, 1);
        chk("f0_end_field", field_o, 1);
        chk("f0_end_fcount", frame_count_o, 1);
        chk("f0_end_frames", n_frame, 1);

        // Frame 1: PAL interlace, field 1, long final line
        pal_i = 1'b0; interlace_i = 1'b0;
        run(311 * 1364);
        chk("pal_l311_v", vcount_o, 311);
        chk("pal_l311_h", hcount_o, 0);
        clear_dots();
        run(1364);
        chk("pal_h340", hcount_o, 340);
        chk("pal_h340_v", vcount_o, 311);
        chk("pal_h340_mclk", mclk_o, 1364);
        chk("pal_h340_newline", newline_o, 0);
        run(4);
        chk("pal_end_v", vcount_o, 0);
        chk("pal_end_h", hcount_o, 0);
        chk("pal_end_mclk", mclk_o, 0);
        chk("pal_end_newframe", newframe_o, 1);
        chk("pal_end_field", field_o, 0);
        chk("pal_end_fcount", frame_count_o, 2);
        chk("pal_len_h323", dot_len[323], 6);
        chk("pal_len_h340", dot_len[340], 4);

        // Frame 2: NTSC field 0, all normal lines
        run(262 * 1364 - 1);
        chk("f2_last_v", vcount_o, 261);
        chk("f2_last_h", hcount_o, 339);
        tick();
        chk("f2_end_v", vcount_o, 0);
        chk("f2_end_newframe", newframe_o, 1);
        chk("f2_end_field", field_o, 1);
        chk("f2_end_fcount", frame_count_o, 3);

        // Frame 3: NTSC non-interlace, field 1, short line 240
        run(240 * 1364);
        chk("short_v", vcount_o, 240);
        chk("short_h", hcount_o, 0);
        clear_dots();
        done = n_line;
        run(1359);
        chk("short_1359_h", hcount_o, 339);
        chk("short_1359_mclk", mclk_o, 1359);
        chk("short_1359_lines", n_line - done, 0);
        tick();
        chk("short_end_v", vcount_o, 241);
        chk("short_end_h", hcount_o, 0);
        chk("short_end_mclk", mclk_o, 0);
        chk("short_end_newline", newline_o, 1);
        bad = 0;
        for (int h = 0; h < 340; h++) if (dot_len[h] != 4) bad++;
        chk("short_dots_not_4", bad, 0);
        chk("short_len_h323", dot_len[323], 4);
        chk("short_len_h327", dot_len[327], 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ppu_hv_counter.md
PPU_HV_COUNTER -- requirements
Module: ppu_hv_counter

Interface
REQ-001 Ports `clock` and `reset` SHALL form the only clock domain; `reset` is asynchronous and active-high.
REQ-002 Port list SHALL be:
- `clock`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `xin_tick_i`, in, 1: one-cycle pulse per PPU master-clock (xin) rising edge, from ppu_clock; absent while ppu_clock is stalled.
- `pal_i`, in, 1: 1 = PAL, 312 lines; 0 = NTSC, 262 lines.
- `interlace_i`, in, 1: interlace mode.
- `mclk_o`, out, 11: master-clock position within the line.
- `hcount_o`, out, 9: dot number H.
- `vcount_o`, out, 9: line number V.
- `dot_o`, out, 1: one-cycle pulse on each dot boundary.
- `newline_o`, out, 1: one-cycle pulse when H wraps to 0.
- `newframe_o`, out, 1: one-cycle pulse when V wraps to 0.
- `field_o`, out, 1: field bit.
- `hblank_o`, out, 1: horizontal blank.
- `vblank_o`, out, 1: vertical blank.
- `frame_count_o`, out, 16: frames completed.

Function
REQ-003 All state SHALL advance only in cycles where `xin_tick_i`=1; with `xin_tick_i`=0 every output SHALL hold, and pulse outputs SHALL be 0.
REQ-004 Each tick SHALL increment `mclk_o` and an internal dot phase; every output SHALL be registered and SHALL update in the cycle after the tick.
REQ-005 Dot length SHALL be 4 ticks, except H=323 and H=327, which SHALL be 6 ticks on normal lines.
REQ-006 On the tick ending a dot: phase←0, H←H+1 and `dot_o`=1.
REQ-007 Normal line: dots 0..339 = 1364 ticks.
REQ-008 Short line: applies when `pal_i`=0, `interlace_i`=0, `field_o`=1 and V=240. It SHALL have dots 0..339, all 4 ticks long, 1360 ticks in total.
REQ-009 Long line: applies when `pal_i`=1, `interlace_i`=1, `field_o`=1 and V=311. It SHALL have dots 0..340 (H=340 legal), with long dots as normal, 1368 ticks in total.
REQ-010 At the end of the last dot of a line: H←0, `mclk_o`←0, V←V+1 and `newline_o`=1.
REQ-011 Frame end occurs after V=261 (NTSC) or V=311 (PAL). At frame end: V←0, `field_o` toggles, `frame_count_o` increments (wrapping 65535→0) and `newframe_o`=1.
REQ-012 `pal_i` and `interlace_i` SHALL be sampled only at reset release and at frame end; mid-frame changes SHALL have no effect until the next frame.
REQ-013 `hblank_o` SHALL be 1 when H≥274 or H=0.
REQ-014 `vblank_o` SHALL be 1 when V≥225 or V=0.
REQ-015 Short-line and long-line qualification SHALL use `field_o` as it stands during that line.

Reset
REQ-016 While `reset`=1 the block SHALL force:
- `mclk_o`, H, V, dot phase, `field_o` and `frame_count_o` to 0.
- All pulse outputs to 0.
- `hblank_o`=1 and `vblank_o`=1.
REQ-017 Reset asserted mid-line SHALL clear state immediately, without waiting for a clock edge.
REQ-018 After release, the first tick SHALL yield `mclk_o`=1 and H=0.

Structure
REQ-019 Package `ppu_timing_pkg` SHALL hold the timing constants:
- Line lengths 1364, 1360 and 1368.
- Long-dot positions 323 and 327.
- Line counts 262 and 312.
- Blank thresholds 274 and 225.
- Short-line index 240.
REQ-020 Sub-module `ppu_dot_divider` SHALL hold the dot-phase and length logic, taking H and the line type as inputs and producing the end-of-dot pulse.

Verification
REQ-021 NTSC, reset released, 1364 ticks: `dot_o` SHALL pulse 340 times; dots 323 and 327 SHALL last 6 ticks each; the line SHALL end with H=0, V=1 and one `newline_o`.
REQ-022 NTSC non-interlace, `field_o`=1, line 240: `newline_o` SHALL pulse after exactly 1360 ticks, and every dot SHALL last 4 ticks.
REQ-023 PAL interlace, `field_o`=1, line 311: H SHALL reach 340, the line SHALL last 1368 ticks, and then V=0 with `newframe_o`=1.
REQ-024 NTSC, 262×1364 ticks from reset (`field_o`=0): V SHALL be 0, `field_o`=1, `frame_count_o`=1, and `newframe_o` SHALL pulse exactly once.
REQ-025 Stall, with `xin_tick_i` held 0 for 50 cycles at H=100: all outputs SHALL be unchanged, and the next tick SHALL continue the count exactly.
REQ-026 Reset pulsed between clock edges at H=200, V=50: outputs SHALL clear before the next edge; on release, counting SHALL restart per REQ-018.
